// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter shared by the instruction cache and the load/store buffer.
// One request at a time is served; ties alternate between the two masters.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IC_req,
  input  logic [31:0] IC_addr,
  output logic        IC_done,
  output logic [31:0] IC_data,
  input  logic        LSB_req,
  input  logic        LSB_wr,
  input  logic [31:0] LSB_addr,
  input  logic [1:0]  LSB_len,
  input  logic [31:0] LSB_wdata,
  output logic        LSB_done,
  output logic [31:0] LSB_rdata,
  input  logic        ROB_clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [1:0]  dbg_state
);

  // Handshake: a master raises req with stable address/data and holds it until
  // its done pulse; the request still visible during the DONE cycle is stale
  // and is never re-granted, so only the other master can be granted there.
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic        owner;        // 0 = IC, 1 = LSB
  logic        last_grant;   // 0 = IC, 1 = LSB
  logic [2:0]  cnt;
  logic [2:0]  n;
  logic [31:0] rbuf;
  logic [31:0] wbuf;
  logic        mem_wr_q;

  logic        ic_cand, lsb_cand, grant_go, grant_lsb, last_byte;
  logic [2:0]  grant_n;
  logic [31:0] rd_word;

  always_comb begin
    ic_cand   = IC_req  && !(state == DONE && owner == 1'b0);
    lsb_cand  = LSB_req && !(state == DONE && owner == 1'b1);
    grant_go  = (state == IDLE || state == DONE) && !ROB_clear && (ic_cand || lsb_cand);
    grant_lsb = (ic_cand && lsb_cand) ? (last_grant == 1'b0) : lsb_cand;
    if (!grant_lsb)            grant_n = 3'd4;
    else if (LSB_len == 2'd0)  grant_n = 3'd1;
    else if (LSB_len == 2'd1)  grant_n = 3'd2;
    else                       grant_n = 3'd4;
    last_byte = (cnt == n - 3'd1);
    rd_word   = rbuf | ({24'h0, mem_din} << {cnt[1:0], 3'b000});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant_go) state_nxt = (grant_lsb && LSB_wr) ? WRITE : READ;
      READ:  if (ROB_clear) state_nxt = IDLE;
             else if (last_byte) state_nxt = DONE;
      WRITE: if (last_byte) state_nxt = DONE;
      DONE:  state_nxt = grant_go ? ((grant_lsb && LSB_wr) ? WRITE : READ) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 3'd0;
      n          <= 3'd4;
      rbuf       <= 32'h0;
      wbuf       <= 32'h0;
      mem_a      <= 32'h0;
      mem_dout   <= 8'h0;
      mem_wr_q   <= 1'b0;
      IC_done    <= 1'b0;
      LSB_done   <= 1'b0;
      IC_data    <= 32'h0;
      LSB_rdata  <= 32'h0;
    end else if (rdy) begin
      IC_done  <= 1'b0;
      LSB_done <= 1'b0;
      if (grant_go) begin
        owner      <= grant_lsb;
        last_grant <= grant_lsb;
        cnt        <= 3'd0;
        n          <= grant_n;
        rbuf       <= 32'h0;
        wbuf       <= LSB_wdata;
        mem_a      <= grant_lsb ? LSB_addr : IC_addr;
        mem_dout   <= LSB_wdata[7:0];
        mem_wr_q   <= grant_lsb && LSB_wr;
      end else begin
        case (state)
          READ: if (!ROB_clear) begin
            if (last_byte) begin
              if (owner) begin
                LSB_done  <= 1'b1;
                LSB_rdata <= rd_word;
              end else begin
                IC_done <= 1'b1;
                IC_data <= rd_word;
              end
            end else begin
              rbuf  <= rd_word;
              cnt   <= cnt + 3'd1;
              mem_a <= mem_a + 32'd1;
            end
          end
          // A store is already committed, so a flush does not interrupt it.
          WRITE: if (last_byte) begin
            mem_wr_q <= 1'b0;
            LSB_done <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            mem_a    <= mem_a + 32'd1;
            mem_dout <= wbuf[15:8];
            wbuf     <= {8'h0, wbuf[31:8]};
          end
          default: ;
        endcase
      end
    end
  end

  // A stalled write cycle must not strobe the RAM; the byte is reissued later.
  assign mem_wr    = mem_wr_q && rdy;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, transaction-level
// reference memory and latency model, directed scenarios plus random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        IC_req, IC_done;
  logic [31:0] IC_addr, IC_data;
  logic        LSB_req, LSB_wr, LSB_done;
  logic [31:0] LSB_addr, LSB_wdata, LSB_rdata;
  logic [1:0]  LSB_len;
  logic        ROB_clear;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IC_req(IC_req), .IC_addr(IC_addr), .IC_done(IC_done), .IC_data(IC_data),
    .LSB_req(LSB_req), .LSB_wr(LSB_wr), .LSB_addr(LSB_addr), .LSB_len(LSB_len),
    .LSB_wdata(LSB_wdata), .LSB_done(LSB_done), .LSB_rdata(LSB_rdata),
    .ROB_clear(ROB_clear), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- RAM: 8 KiB window, address bits [12:0] ----------------
  logic [7:0]  ram     [0:8191];
  bit          ram_set [0:8191];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  function automatic logic [7:0] init_byte(input logic [12:0] idx);
    case (idx)
      13'h100: return 8'h13;
      13'h101: return 8'h05;
      13'h102: return 8'h00;
      13'h103: return 8'h00;
      default: return idx[7:0] ^ {3'b000, idx[12:8]} ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_set[a[12:0]] ? ram[a[12:0]] : init_byte(a[12:0]);
  endfunction

  always @(negedge clk) mem_din <= ram_rd(mem_a);

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[12:0]]     <= mem_dout;
      ram_set[mem_a[12:0]] <= 1'b1;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:8191];
  bit          ref_set [0:8191];
  logic [31:0] exp_q[$];
  logic [31:0] trace[$];
  bit          model_last;   // master served most recently: 0 = IC, 1 = LSB

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_set[a[12:0]] ? ref_mem[a[12:0]] : init_byte(a[12:0]);
  endfunction

  function automatic int nbytes(input bit is_ic, input logic [1:0] len);
    if (is_ic) return 4;
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int nb);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < nb; i++) w = w | (32'(ref_rd(a + 32'(i))) << (8 * i));
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int nb, input logic [31:0] d);
    for (int i = 0; i < nb; i++) begin
      ref_mem[(a + 32'(i)) & 32'h1FFF] = d[8*i +: 8];
      ref_set[(a + 32'(i)) & 32'h1FFF] = 1'b1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic run_req(input bit is_ic, input bit wr, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wdata,
                         input int clr_at, input int stall_at, input int stall_len,
                         output logic [31:0] data, output int cycles, output int wr_cnt);
    bit got = 0;
    trace.delete();
    cycles = 0; wr_cnt = 0; data = 'x;
    @(negedge clk);
    if (is_ic) begin
      IC_req = 1'b1; IC_addr = addr;
    end else begin
      LSB_req = 1'b1; LSB_wr = wr; LSB_addr = addr; LSB_len = len; LSB_wdata = wdata;
    end
    model_last = !is_ic;
    while (!got && cycles < 60) begin
      @(negedge clk);
      cycles++;
      trace.push_back(mem_a);
      if (mem_wr) wr_cnt++;
      if (!rdy) begin
        n_cmp++;
        if (mem_wr !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_mem_wr cycle %0d got %b exp 0", cycles, mem_wr);
        end
      end
      if (stall_len > 0 && cycles == stall_at) rdy = 1'b0;
      if (stall_len > 0 && cycles == stall_at + stall_len) rdy = 1'b1;
      if (clr_at > 0 && cycles == clr_at) ROB_clear = 1'b1;
      if (is_ic ? IC_done : LSB_done) begin
        got  = 1;
        data = is_ic ? IC_data : LSB_rdata;
      end
    end
    IC_req = 1'b0; LSB_req = 1'b0; ROB_clear = 1'b0; rdy = 1'b1;
  endtask

  // Both masters request together: the one not served last goes first, and the
  // other is granted on the edge that ends the winner's done cycle.
  task automatic tie_round(input logic [31:0] ia, input logic [31:0] la);
    int ic_c = -1, lsb_c = -1, exp_ic_c, exp_lsb_c;
    logic [31:0] id = 'x, ld = 'x;
    bit ic_first = (model_last == 1'b1);
    exp_ic_c  = ic_first ? 5 : 10;
    exp_lsb_c = ic_first ? 10 : 5;
    exp_q.push_back(ref_word(ia, 4));
    exp_q.push_back(ref_word(la, 4));
    @(negedge clk);
    IC_req = 1'b1; IC_addr = ia;
    LSB_req = 1'b1; LSB_wr = 1'b0; LSB_addr = la; LSB_len = 2'd2;
    for (int c = 1; c <= 40 && (ic_c < 0 || lsb_c < 0); c++) begin
      @(negedge clk);
      if (IC_done)  begin ic_c = c;  id = IC_data;   IC_req = 1'b0;  end
      if (LSB_done) begin lsb_c = c; ld = LSB_rdata; LSB_req = 1'b0; end
    end
    IC_req = 1'b0; LSB_req = 1'b0;
    model_last = ic_first ? 1'b1 : 1'b0;
    n_cmp += 4;
    if (ic_c !== exp_ic_c) begin n_bad++; $display("FAIL tie_ic_cycle got %0d exp %0d", ic_c, exp_ic_c); end
    if (lsb_c !== exp_lsb_c) begin n_bad++; $display("FAIL tie_lsb_cycle got %0d exp %0d", lsb_c, exp_lsb_c); end
    if (id !== exp_q[0]) begin n_bad++; $display("FAIL tie_ic_data got %h exp %h", id, exp_q[0]); end
    if (ld !== exp_q[1]) begin n_bad++; $display("FAIL tie_lsb_data got %h exp %h", ld, exp_q[1]); end
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp += 7;
    if (IC_done !== 1'b0 || LSB_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b%b exp 00", IC_done, LSB_done); end
    if (IC_data !== 32'h0) begin n_bad++; $display("FAIL reset_ic_data got %h exp 0", IC_data); end
    if (LSB_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_lsb_rdata got %h exp 0", LSB_rdata); end
    if (mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
    if (mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
    if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
    if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_arbitration();
    logic [31:0] d; int c, w;
    tie_round(32'h100, 32'h200);
    tie_round(32'h100, 32'h200);
    run_req(1, 0, 32'h104, 2'd2, 32'h0, 0, 0, 0, d, c, w);
    n_cmp++;
    if (d !== ref_word(32'h104, 4)) begin n_bad++; $display("FAIL solo_ic_data got %h exp %h", d, ref_word(32'h104, 4)); end
    tie_round(32'h108, 32'h20C);
  endtask

  task automatic test_ic_fetch();
    logic [31:0] d; int c, w;
    run_req(1, 0, 32'h100, 2'd0, 32'h0, 0, 0, 0, d, c, w);
    n_cmp += 3;
    if (d !== 32'h00000513) begin n_bad++; $display("FAIL fetch_data got %h exp 00000513", d); end
    if (c !== 5) begin n_bad++; $display("FAIL fetch_cycles got %0d exp 5", c); end
    if (trace[0] !== 32'h100 || trace[1] !== 32'h101 || trace[2] !== 32'h102 || trace[3] !== 32'h103) begin
      n_bad++;
      $display("FAIL fetch_addr_seq got %h %h %h %h exp 100..103", trace[0], trace[1], trace[2], trace[3]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; int c, w;
    run_req(0, 0, 32'hFFFF_FFFE, 2'd3, 32'h0, 0, 0, 0, d, c, w);
    n_cmp += 2;
    if (trace[2] !== 32'h0 || trace[3] !== 32'h1) begin n_bad++; $display("FAIL wrap_addr got %h %h exp 0 1", trace[2], trace[3]); end
    if (d !== ref_word(32'hFFFF_FFFE, 4)) begin n_bad++; $display("FAIL wrap_data got %h exp %h", d, ref_word(32'hFFFF_FFFE, 4)); end
  endtask

  task automatic test_store();
    logic [31:0] d; int c, w, base;
    base = wlog_a.size();
    run_req(0, 1, 32'h1001, 2'd1, 32'hAABBCCDD, 0, 0, 0, d, c, w);
    ref_store(32'h1001, 2, 32'hAABBCCDD);
    n_cmp += 4;
    if (c !== 3) begin n_bad++; $display("FAIL store_cycles got %0d exp 3", c); end
    if (w !== 2) begin n_bad++; $display("FAIL store_wr_cycles got %0d exp 2", w); end
    if (wlog_a.size() - base !== 2) begin n_bad++; $display("FAIL store_write_count got %0d exp 2", wlog_a.size() - base); end
    else if (wlog_a[base] !== 32'h1001 || wlog_d[base] !== 8'hDD || wlog_a[base+1] !== 32'h1002 || wlog_d[base+1] !== 8'hCC) begin
      n_bad++;
      $display("FAIL store_writes got (%h,%h) (%h,%h) exp (1001,dd) (1002,cc)", wlog_a[base], wlog_d[base], wlog_a[base+1], wlog_d[base+1]);
    end
    else if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL store_wr_after got %b exp 0", mem_wr); end
  endtask

  task automatic test_rob_clear();
    logic [31:0] d, prev; int c, w, base; bit seen = 0;
    prev = IC_data;
    @(negedge clk);
    IC_req = 1'b1; IC_addr = 32'h300;
    model_last = 1'b0;
    repeat (2) @(negedge clk);
    ROB_clear = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL abort_state got %0d exp 0", dbg_state); end
    if (IC_done) seen = 1;
    IC_req = 1'b0; ROB_clear = 1'b0;
    repeat (8) begin @(negedge clk); if (IC_done) seen = 1; end
    n_cmp += 2;
    if (seen) begin n_bad++; $display("FAIL abort_done got 1 exp 0"); end
    if (IC_data !== prev) begin n_bad++; $display("FAIL abort_ic_data got %h exp %h", IC_data, prev); end
    base = wlog_a.size();
    run_req(0, 1, 32'h1100, 2'd2, 32'h11223344, 1, 0, 0, d, c, w);
    ref_store(32'h1100, 4, 32'h11223344);
    n_cmp += 2;
    if (c !== 5) begin n_bad++; $display("FAIL clr_store_cycles got %0d exp 5", c); end
    if (wlog_a.size() - base !== 4 || wlog_d[base+3] !== 8'h11 || wlog_a[base+3] !== 32'h1103) begin
      n_bad++; $display("FAIL clr_store_writes got %0d writes exp 4", wlog_a.size() - base);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d; int c, w, base;
    run_req(0, 0, 32'h2100, 2'd2, 32'h0, 0, 2, 3, d, c, w);
    n_cmp += 2;
    if (c !== 8) begin n_bad++; $display("FAIL stall_load_cycles got %0d exp 8", c); end
    if (d !== ref_word(32'h2100, 4)) begin n_bad++; $display("FAIL stall_load_data got %h exp %h", d, ref_word(32'h2100, 4)); end
    base = wlog_a.size();
    run_req(0, 1, 32'h2200, 2'd1, 32'h0000BEEF, 0, 1, 3, d, c, w);
    ref_store(32'h2200, 2, 32'h0000BEEF);
    n_cmp += 2;
    if (c !== 6) begin n_bad++; $display("FAIL stall_store_cycles got %0d exp 6", c); end
    if (wlog_a.size() - base !== 2 || wlog_d[base] !== 8'hEF || wlog_d[base+1] !== 8'hBE || wlog_a[base+1] !== 32'h2201) begin
      n_bad++; $display("FAIL stall_store_writes got %0d writes exp 2", wlog_a.size() - base);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen = 0;
    @(negedge clk);
    IC_req = 1'b1; IC_addr = 32'h400;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp += 4;
    if (IC_done !== 1'b0 || LSB_done !== 1'b0 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mid_strobes got %b%b%b exp 000", IC_done, LSB_done, mem_wr); end
    if (IC_data !== 32'h0 || LSB_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mid_data got %h %h exp 0 0", IC_data, LSB_rdata); end
    if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin n_bad++; $display("FAIL rst_mid_mem got %h %h exp 0 0", mem_a, mem_dout); end
    if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_mid_state got %0d exp 0", dbg_state); end
    @(negedge clk);
    IC_req = 1'b0; rst = 1'b0;
    model_last = 1'b1;
    repeat (8) begin @(negedge clk); if (IC_done) seen = 1; end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rst_mid_done got 1 exp 0"); end
  endtask

  task automatic test_random();
    logic [31:0] d, a, wd; int c, w, kind, nb; logic [1:0] len;
    for (int it = 0; it < 40; it++) begin
      a = 32'h2000 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) begin
        tie_round(a, 32'h2000 + 32'($urandom_range(0, 31)));
      end else begin
        kind = $urandom_range(0, 2);
        len  = 2'($urandom_range(0, 3));
        wd   = $urandom;
        nb   = nbytes(kind == 0, len);
        if (kind == 2) begin
          run_req(0, 1, a, len, wd, 0, 0, 0, d, c, w);
          ref_store(a, nb, wd);
          n_cmp++;
          if (w !== nb) begin n_bad++; $display("FAIL rand_store_wr it %0d got %0d exp %0d", it, w, nb); end
        end else begin
          exp_q.push_back(ref_word(a, nb));
          run_req(kind == 0, 0, a, len, 32'h0, 0, 0, 0, d, c, w);
          n_cmp++;
          if (d !== exp_q[0]) begin n_bad++; $display("FAIL rand_read_data it %0d got %h exp %h", it, d, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        n_cmp++;
        if (c !== nb + 1) begin n_bad++; $display("FAIL rand_cycles it %0d got %0d exp %0d", it, c, nb + 1); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; ROB_clear = 1'b0;
    IC_req = 1'b0; IC_addr = 32'h0;
    LSB_req = 1'b0; LSB_wr = 1'b0; LSB_addr = 32'h0; LSB_len = 2'd0; LSB_wdata = 32'h0;
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_arbitration();
    test_ic_fetch();
    test_wrap();
    test_store();
    test_rob_clear();
    test_stall();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
